// File: rtl/upi_payment_ctrl.sv
// UPI payment controller: offers a transaction to the bank link, waits for a
// tagged response with timeout/retry, and reports approve/fail as one-cycle pulses.
module upi_payment_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pay_req,
    input  logic [7:0] amount,
    output logic       txn_valid,
    input  logic       txn_ready,
    output logic [7:0] txn_amount,
    output logic [7:0] txn_id,
    input  logic       resp_valid,
    input  logic       resp_ok,
    input  logic [7:0] resp_id,
    output logic       pay_done,
    output logic       pay_fail,
    output logic       busy
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESP,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        r_state;
    logic [7:0]    r_amount;
    logic [7:0]    r_id;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_retry;

    state_t        w_state_nxt;
    logic [7:0]    w_amount_nxt;
    logic [7:0]    w_id_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [RW-1:0] w_retry_nxt;
    logic          w_resp_match;

    assign w_resp_match = resp_valid && (resp_id == r_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_amount <= '0;
            r_id     <= '0;
            r_timer  <= '0;
            r_retry  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_amount <= w_amount_nxt;
            r_id     <= w_id_nxt;
            r_timer  <= w_timer_nxt;
            r_retry  <= w_retry_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_amount_nxt = r_amount;
        w_id_nxt     = r_id;
        w_timer_nxt  = r_timer;
        w_retry_nxt  = r_retry;
        unique case (r_state)
            S_IDLE: begin
                if (pay_req) begin
                    if (amount != 8'd0) begin
                        w_amount_nxt = amount;
                        w_id_nxt     = r_id + 8'd1;
                        w_retry_nxt  = '0;
                        w_state_nxt  = S_SEND;
                    end else begin
                        w_state_nxt  = S_FAIL;
                    end
                end
            end
            S_SEND: begin
                if (txn_ready) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                // A matching response takes priority over a timeout in the same cycle.
                if (w_resp_match) begin
                    w_state_nxt = resp_ok ? S_DONE : S_FAIL;
                end else if (r_timer == TIMER_LAST) begin
                    if (r_retry < RETRY_MAX) begin
                        w_retry_nxt = r_retry + RW'(1);
                        w_state_nxt = S_SEND;
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAIL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign txn_valid  = (r_state == S_SEND);
    assign txn_amount = r_amount;
    assign txn_id     = r_id;
    assign pay_done   = (r_state == S_DONE);
    assign pay_fail   = (r_state == S_FAIL);
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/upi_payment_ctrl.md
UPI_PAYMENT_CTRL -- requirements
Module: upi_payment_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: cycles to wait for a bank response after each send.
REQ-002 Parameter MAX_RETRY, default 2: resends allowed after a timeout before failing.
REQ-003 The block SHALL have one clock, `clk`, and an asynchronous active-low reset, `rst_n`.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pay_req  input  1  payment request from the vending FSM; level, sampled in IDLE only.
REQ-007 amount  input  8  price to charge; sampled with pay_req.
REQ-008 txn_valid  output  1  transaction offer to the bank link.
REQ-009 txn_ready  input  1  bank link accepts the offer.
REQ-010 txn_amount  output  8  latched amount; stable while txn_valid=1.
REQ-011 txn_id  output  8  current transaction tag; stable while txn_valid=1.
REQ-012 resp_valid  input  1  one-cycle bank response strobe.
REQ-013 resp_ok  input  1  1 = payment approved, 0 = declined; qualified by resp_valid.
REQ-014 resp_id  input  8  tag of the response; qualified by resp_valid.
REQ-015 pay_done  output  1  one-cycle pulse: payment approved; drives the vending FSM's upi_pay_done.
REQ-016 pay_fail  output  1  one-cycle pulse: declined, timed out, or zero amount.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The state machine SHALL use five states: IDLE, SEND, WAIT_RESP, DONE and FAIL.
- All outputs decode from registered state and latched registers only.
REQ-019 In IDLE, pay_req=1 with amount!=0 at edge N SHALL:
- latch amount;
- increment txn_id (mod 256, 255->0);
- clear the retry count;
- enter SEND, so txn_valid=1 in cycle N+1.
REQ-020 In IDLE, pay_req=1 with amount==0 SHALL enter FAIL, giving one pay_fail pulse and no txn_valid.
REQ-021 In SEND, txn_valid SHALL stay 1 with txn_amount and txn_id unchanged until txn_valid&&txn_ready.
- On that handshake: go to WAIT_RESP and clear the timeout timer.
- No timeout applies in SEND.
REQ-022 In WAIT_RESP, the timer SHALL increment every cycle.
REQ-023 In WAIT_RESP, a response with resp_valid=1 and resp_id==txn_id SHALL move to DONE if resp_ok=1, else to FAIL.
- A decline is never retried.
REQ-024 In WAIT_RESP, a response with resp_id!=txn_id SHALL be ignored.
- The timer keeps running.
REQ-025 When the timer reaches TIMEOUT_CYC-1 without a matching response:
- retry count < MAX_RETRY: increment the retry count and return to SEND with the same txn_id and amount;
- otherwise: go to FAIL.
REQ-026 If a matching response and the timeout occur in the same cycle, the response SHALL win.
REQ-027 DONE SHALL assert pay_done for exactly one cycle, then go to IDLE.
REQ-028 FAIL SHALL assert pay_fail for exactly one cycle, then go to IDLE.
REQ-029 pay_done and pay_fail SHALL never be high together.
REQ-030 pay_req and amount changes outside IDLE SHALL be ignored.
- A request still held high on return to IDLE starts a new transaction.
REQ-031 resp_valid outside WAIT_RESP SHALL be ignored.
REQ-032 Latency, matching approve response sampled at edge M: pay_done=1 during cycle M+1.
REQ-033 Timer and retry counter widths SHALL be sized from their parameters, with no wrap before the terminal count.

Reset
REQ-034 On rst_n=0, regardless of state, the block SHALL asynchronously set:
- state=IDLE;
- txn_valid=0, pay_done=0, pay_fail=0, busy=0;
- txn_amount=0, txn_id=0;
- timer=0, retry count=0.
REQ-035 Reset mid-transaction SHALL drop the offer without a pulse.
- The first request after reset uses txn_id=1.

Verification
REQ-036 Approve path:
- Stimulus: reset, then pay_req=1 with amount=27; txn_ready=1 at the first offer; resp_valid=1, resp_ok=1, resp_id=1 three cycles later.
- Required: txn_amount=27, txn_id=1, exactly one pay_done, busy low after it.
REQ-037 Backpressure:
- Stimulus: txn_ready=0 for 5 cycles.
- Required: txn_valid held for all 5 cycles with txn_amount and txn_id stable; handshake on the 6th cycle.
REQ-038 Timeout and retry:
- Stimulus: no response, defaults TIMEOUT_CYC=16 and MAX_RETRY=2.
- Required: 3 offers, all with txn_id=1, then one pay_fail; no pay_done.
REQ-039 Decline, stale ID and collision:
- Stimulus 1: resp_id=0 sent first.
- Required 1: ignored.
- Stimulus 2: resp_ok=0 with resp_id=1.
- Required 2: pay_fail, no retry.
- Stimulus 3: a matching approve in the timeout cycle.
- Required 3: pay_done.
REQ-040 Edge cases:
- Stimulus 1: amount=0.
- Required 1: immediate pay_fail, txn_valid never asserted.
- Stimulus 2: rst_n low during WAIT_RESP.
- Required 2: all outputs 0 at once; next txn_id=1.
- Stimulus 3: run 256 transactions.
- Required 3: txn_id wraps from 255 to 0.
